// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared types and width helpers for the parametrised DCO
package dco_pkg;

  // Oscillator control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dco_state_e;

  localparam int CTRL_W_DEF = 8;
  localparam int GAIN_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;

  // Guard bits so product, subtraction and clamp compares never overflow
  localparam int EXT_GUARD = 2;

  function automatic int ext_w(input int cnt_w, input int ctrl_w, input int gain_w);
    return cnt_w + ctrl_w + gain_w + EXT_GUARD;
  endfunction

endpackage

// File: rtl/dco_param_if.sv
// rtl/dco_param_if.sv - control inputs and status outputs of the parametrised DCO
interface dco_param_if import dco_pkg::*; #(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              en;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_valid;
  logic [GAIN_W-1:0] kdco;
  logic [CNT_W-1:0]  thresh_base;
  logic [CNT_W-1:0]  thresh_min;
  logic [CNT_W-1:0]  thresh_max;
  logic              dco_clk;
  logic              edge_pulse;
  logic [CNT_W-1:0]  cur_thresh;
  logic              sat_hi;
  logic              sat_lo;

  modport master (
    output en, ctrl, ctrl_valid, kdco, thresh_base, thresh_min, thresh_max,
    input  dco_clk, edge_pulse, cur_thresh, sat_hi, sat_lo
  );

  modport slave (
    input  en, ctrl, ctrl_valid, kdco, thresh_base, thresh_min, thresh_max,
    output dco_clk, edge_pulse, cur_thresh, sat_hi, sat_lo
  );

endinterface

// File: rtl/dco_thresh_calc.sv
// rtl/dco_thresh_calc.sv - gain/shift/subtract/clamp of the half-period threshold (DCO_DITHER_EN adds carry in)
module dco_thresh_calc import dco_pkg::*; #(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [CTRL_W-1:0] ctrl_q,
  input  logic [GAIN_W-1:0]        kdco,
  input  logic [CNT_W-1:0]         thresh_base,
  input  logic [CNT_W-1:0]         thresh_min,
  input  logic [CNT_W-1:0]         thresh_max,
`ifdef DCO_DITHER_EN
  input  logic                     carry_in,
  output logic [FRAC_W-1:0]        frac,
`endif
  output logic [CNT_W-1:0]         thresh,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int EW = ext_w(CNT_W, CTRL_W, GAIN_W);

  logic signed [EW-1:0] ctrl_x;
  logic signed [EW-1:0] kdco_x;
  logic signed [EW-1:0] p;
  logic signed [EW-1:0] phase;
  logic signed [EW-1:0] base_x;
  logic signed [EW-1:0] min_x;
  logic signed [EW-1:0] max_x;
  logic signed [EW-1:0] t;
  logic signed [EW-1:0] t_lo;

  // Signed product, floor shift, subtract from base, then lower and upper clamp
  always_comb begin
    ctrl_x = {{(EW-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q};
    kdco_x = {{(EW-GAIN_W){1'b0}}, kdco};
    base_x = {{(EW-CNT_W){1'b0}}, thresh_base};
    min_x  = {{(EW-CNT_W){1'b0}}, thresh_min};
    max_x  = {{(EW-CNT_W){1'b0}}, thresh_max};
    p      = ctrl_x * kdco_x;
    phase  = p >>> FRAC_W;
`ifdef DCO_DITHER_EN
    phase  = phase + $signed({{(EW-1){1'b0}}, carry_in});
    frac   = p[FRAC_W-1:0];
`endif
    t      = base_x - phase;
    sat_lo = (t < min_x);
    t_lo   = sat_lo ? min_x : t;
    // An inverted window (min > max) always lands on thresh_max here
    sat_hi = (t_lo > max_x);
    thresh = sat_hi ? thresh_max : (sat_lo ? thresh_min : t[CNT_W-1:0]);
  end

endmodule

// File: rtl/dco_param.sv
// rtl/dco_param.sv - parametrised ADPLL DCO top: ctrl capture, FSM, half-period counter (DCO_DITHER_EN optional)
module dco_param import dco_pkg::*; #(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input logic        clk,
  input logic        reset,
  dco_param_if.slave bus
);

  logic signed [CTRL_W-1:0] ctrl_q;
  dco_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         thr_q, thr_d;
  logic                     dco_q, dco_d;
  logic                     edge_q, edge_d;
  logic                     sat_hi_q, sat_hi_d;
  logic                     sat_lo_q, sat_lo_d;
  logic                     load;
  logic [CNT_W-1:0]         t_new;
  logic                     t_hi, t_lo;

  // Loop-filter word is latched so all threshold math sees a stable value
  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else if (bus.ctrl_valid) ctrl_q <= bus.ctrl;
  end

`ifdef DCO_DITHER_EN
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W:0]   acc_sum;
  logic              dith_carry;

  assign acc_sum    = {1'b0, acc_q} + {1'b0, frac};
  assign dith_carry = acc_sum[FRAC_W];

  // Fractional accumulator advances only when a new threshold is taken
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else if (load) acc_q <= acc_sum[FRAC_W-1:0];
  end
`endif

  dco_thresh_calc #(
    .CTRL_W(CTRL_W), .GAIN_W(GAIN_W), .CNT_W(CNT_W), .FRAC_W(FRAC_W)
  ) u_calc (
    .ctrl_q      (ctrl_q),
    .kdco        (bus.kdco),
    .thresh_base (bus.thresh_base),
    .thresh_min  (bus.thresh_min),
    .thresh_max  (bus.thresh_max),
`ifdef DCO_DITHER_EN
    .carry_in    (dith_carry),
    .frac        (frac),
`endif
    .thresh      (t_new),
    .sat_hi      (t_hi),
    .sat_lo      (t_lo)
  );

  // Next-state: threshold only reloads at a half-period boundary or on start
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    dco_d    = dco_q;
    edge_d   = 1'b0;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        dco_d = 1'b0;
        cnt_d = '0;
        if (bus.en) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.en) begin
          if (cnt_q == thr_q) begin
            dco_d  = ~dco_q;
            edge_d = 1'b1;
            cnt_d  = '0;
            load   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      thr_d    = t_new;
      sat_hi_d = t_hi;
      sat_lo_d = t_lo;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      thr_q    <= '0;
      dco_q    <= 1'b0;
      edge_q   <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      dco_q    <= dco_d;
      edge_q   <= edge_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign bus.dco_clk    = dco_q;
  assign bus.edge_pulse = edge_q;
  assign bus.cur_thresh = thr_q;
  assign bus.sat_hi     = sat_hi_q;
  assign bus.sat_lo     = sat_lo_q;

endmodule
